// File: rtl/x_23k640_spi.sv
// ---------------------------------------------------------------------------
// x_23k640_spi
// SPI master (mode 0) for the Microchip 23K640 serial SRAM. Each accepted
// request is issued as one byte-mode READ (0x03) or WRITE (0x02) frame of 32
// bits: {cmd, addr[15:0], wdata or 8'h00}, shifted MSB first.
//
// Build option: define X_23K640_ADDR_CHK_EN to add the o_err port. With the
// option, a request whose address lies beyond 8 KB (i_addr[15:13] != 0) is
// accepted but answered with an o_ready/o_err pulse and no SPI frame.
//
// Parameters:
//   p_clk_div  SCK half-period in i_clk cycles (>= 1)
//
// Ports:
//   i_clk      system clock, all logic on the rising edge
//   i_rst      synchronous active-high reset, aborts any frame in flight
//   i_valid    request valid, held by the requester until o_accept
//   i_rd_n_wr  1 = read, 0 = write
//   i_addr     SRAM byte address
//   i_wdata    write data (ignored for reads)
//   o_accept   request captured on this cycle's clock edge
//   o_ready    one-cycle pulse when a transaction finishes
//   o_rdata    last byte read, held between reads
//   o_sck      SPI clock, idle low
//   o_cs_n     SPI chip select, active low
//   o_mosi     serial data to the SRAM SI pin
//   i_miso     serial data from the SRAM SO pin
//   o_err      out-of-range address pulse (X_23K640_ADDR_CHK_EN only)
// ---------------------------------------------------------------------------
module x_23k640_spi #(
  parameter int p_clk_div = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_rd_n_wr,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_accept,
  output logic        o_ready,
  output logic [7:0]  o_rdata,
  output logic        o_sck,
  output logic        o_cs_n,
  output logic        o_mosi,
  input  logic        i_miso
`ifdef X_23K640_ADDR_CHK_EN
  ,
  output logic        o_err
`endif
);

  localparam int DW = $clog2(p_clk_div + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(p_clk_div - 1);
  // The chip-select recovery is D cycles long counting the DONE cycle, so the
  // GAP state itself only needs D-1 cycles (none at all when D is 1).
  localparam logic [DW-1:0] GAP_LAST = DW'((p_clk_div > 1) ? p_clk_div - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_GAP,
    S_ERR
  } state_t;

  state_t        state, state_d;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic          sck_hi;
  logic [31:0]   shreg;
  logic [7:0]    rx_sh;
  logic          is_rd;
  logic [7:0]    rdata_q;

  logic          div_last;
  logic          gap_last;
  logic          frame_on;
  logic          addr_bad;

  // Next-state decode and pin outputs. All pins are decoded from registered
  // state, so they change only on clock edges.
  always_comb begin
    state_d  = state;
    addr_bad = 1'b0;
`ifdef X_23K640_ADDR_CHK_EN
    addr_bad = (i_addr[15:13] != 3'b000);
`endif
    div_last = (div_cnt == DIV_LAST);
    gap_last = (div_cnt == GAP_LAST);
    frame_on = (state == S_SETUP) || (state == S_SHIFT);
    o_accept = (state == S_IDLE) && i_valid;
    o_ready  = (state == S_DONE) || (state == S_ERR);
    o_cs_n   = !frame_on;
    o_sck    = (state == S_SHIFT) && sck_hi;
    o_mosi   = frame_on && shreg[31];

    case (state)
      S_IDLE:  if (o_accept) state_d = addr_bad ? S_ERR : S_SETUP;
      S_SETUP: if (div_last) state_d = S_SHIFT;
      S_SHIFT: if (!sck_hi && div_last && (bit_cnt == 5'd31)) state_d = S_DONE;
      S_DONE:  state_d = (p_clk_div > 1) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_last) state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus datapath. Within SHIFT each bit is a high half then a
  // low half of D cycles; MOSI advances at the falling edge and SO is sampled
  // on the edge that raises SCK for bits 24..31.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck_hi  <= 1'b0;
      shreg   <= '0;
      rx_sh   <= '0;
      is_rd   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          sck_hi  <= 1'b0;
          if (o_accept) begin
            is_rd <= i_rd_n_wr;
            if (!addr_bad) begin
              shreg <= {(i_rd_n_wr ? 8'h03 : 8'h02), i_addr,
                        (i_rd_n_wr ? 8'h00 : i_wdata)};
            end
          end
        end
        S_SETUP: begin
          if (div_last) begin
            div_cnt <= '0;
            sck_hi  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_SHIFT: begin
          if (!div_last) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            if (sck_hi) begin
              sck_hi <= 1'b0;
              shreg  <= {shreg[30:0], 1'b0};
            end else if (bit_cnt == 5'd31) begin
              bit_cnt <= '0;
              if (is_rd) rdata_q <= rx_sh;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              sck_hi  <= 1'b1;
              if (bit_cnt >= 5'd23) rx_sh <= {rx_sh[6:0], i_miso};
            end
          end
        end
        S_DONE: begin
          div_cnt <= '0;
        end
        S_GAP: begin
          if (gap_last) div_cnt <= '0;
          else          div_cnt <= div_cnt + DW'(1);
        end
        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

  assign o_rdata = rdata_q;

`ifdef X_23K640_ADDR_CHK_EN
  assign o_err = (state == S_ERR);
`endif

endmodule

// File: tb/tb_x_23k640_spi.sv
// ---------------------------------------------------------------------------
// tb_x_23k640_spi
// Bench for x_23k640_spi. Two instances: inst 0 with p_clk_div=2 and inst 1
// with p_clk_div=1. A per-instance monitor plays the SRAM SO pin, captures the
// MOSI frame at every SCK rise and checks finished transactions against a
// scoreboard of expectations pushed when each request is accepted.
// ---------------------------------------------------------------------------
module tb_x_23k640_spi;

  typedef struct {
    int          inst;
    bit          err;
    logic [31:0] frame;
    int          rises;
    int          lat;
    int          cs_first;
    int          cs_last;
    logic [7:0]  rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [1:0]       valid_w;
  logic [1:0]       rdnwr_w;
  logic [1:0][15:0] addr_w;
  logic [1:0][7:0]  wdata_w;
  logic [1:0]       acc_w;
  logic [1:0]       ready_w;
  logic [1:0][7:0]  rdata_w;
  logic [1:0]       sck_w;
  logic [1:0]       csn_w;
  logic [1:0]       mosi_w;
  logic [1:0]       miso_w = '0;
`ifdef X_23K640_ADDR_CHK_EN
  logic [1:0]       err_w;
`endif

  int compared   = 0;
  int mismatched = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  exp_rdata [2];
  logic [7:0]  so_byte   [2];
  int          acc_cyc   [2];
  int          rises     [2];
  int          cs_first  [2];
  int          cs_last   [2];
  int          ready_cnt [2];
  int          spurious  [2];
  logic [31:0] cap       [2];
  bit          prev_sck  [2];
  bit          prev_mosi [2];
  bit          bad_edge  [2];
  bit          mosi_unst [2];

  x_23k640_spi #(.p_clk_div(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_w[0]), .i_rd_n_wr(rdnwr_w[0]),
    .i_addr(addr_w[0]), .i_wdata(wdata_w[0]), .o_accept(acc_w[0]),
    .o_ready(ready_w[0]), .o_rdata(rdata_w[0]), .o_sck(sck_w[0]),
    .o_cs_n(csn_w[0]), .o_mosi(mosi_w[0]), .i_miso(miso_w[0])
`ifdef X_23K640_ADDR_CHK_EN
    , .o_err(err_w[0])
`endif
  );

  x_23k640_spi #(.p_clk_div(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_w[1]), .i_rd_n_wr(rdnwr_w[1]),
    .i_addr(addr_w[1]), .i_wdata(wdata_w[1]), .o_accept(acc_w[1]),
    .o_ready(ready_w[1]), .o_rdata(rdata_w[1]), .o_sck(sck_w[1]),
    .o_cs_n(csn_w[1]), .o_mosi(mosi_w[1]), .i_miso(miso_w[1])
`ifdef X_23K640_ADDR_CHK_EN
    , .o_err(err_w[1])
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor and SRAM model, evaluated on the falling clock edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rises[k]     = 0;
        cap[k]       = '0;
        prev_sck[k]  = 1'b0;
        prev_mosi[k] = 1'b0;
        miso_w[k]    = 1'b0;
        cs_first[k]  = -1;
        cs_last[k]   = -1;
      end else begin
        if (acc_w[k]) begin
          checkOutput($sformatf("accept_only_idle%0d", k), csn_w[k], 1);
          acc_cyc[k]   = cyc;
          rises[k]     = 0;
          cap[k]       = '0;
          cs_first[k]  = -1;
          cs_last[k]   = -1;
          bad_edge[k]  = 1'b0;
          mosi_unst[k] = 1'b0;
        end
        if (!csn_w[k]) begin
          if (cs_first[k] < 0) cs_first[k] = cyc;
          cs_last[k] = cyc;
        end
        if (sck_w[k] && !prev_sck[k]) begin
          if (csn_w[k]) bad_edge[k] = 1'b1;
          rises[k]++;
          cap[k] = {cap[k][30:0], mosi_w[k]};
        end
        if (!sck_w[k] && prev_sck[k] && csn_w[k]) bad_edge[k] = 1'b1;
        if (sck_w[k] && prev_sck[k] && (mosi_w[k] != prev_mosi[k]))
          mosi_unst[k] = 1'b1;
        if (!sck_w[k] && prev_sck[k] && rises[k] >= 24 && rises[k] < 32)
          miso_w[k] = so_byte[k][3'(31 - rises[k])];
        prev_sck[k]  = sck_w[k];
        prev_mosi[k] = mosi_w[k];
        if (ready_w[k]) begin
          ready_cnt[k]++;
          if (sb.size() == 0 || sb[0].inst != k) begin
            spurious[k]++;
          end else begin
            mon_e = sb.pop_front();
            checkOutput($sformatf("latency%0d", k), cyc - acc_cyc[k], mon_e.lat);
            checkOutput($sformatf("sck_rises%0d", k), rises[k], mon_e.rises);
            checkOutput($sformatf("mosi_frame%0d", k), cap[k], mon_e.frame);
            checkOutput($sformatf("cs_first%0d", k),
                        (cs_first[k] < 0) ? -1 : cs_first[k] - acc_cyc[k],
                        mon_e.cs_first);
            checkOutput($sformatf("cs_last%0d", k),
                        (cs_last[k] < 0) ? -1 : cs_last[k] - acc_cyc[k],
                        mon_e.cs_last);
            checkOutput($sformatf("rdata%0d", k), rdata_w[k], mon_e.rdata);
            checkOutput($sformatf("done_pins%0d", k), {csn_w[k], sck_w[k]}, 2'b10);
            checkOutput($sformatf("sck_while_cs_high%0d", k), bad_edge[k], 0);
            checkOutput($sformatf("mosi_unstable%0d", k), mosi_unst[k], 0);
`ifdef X_23K640_ADDR_CHK_EN
            checkOutput($sformatf("err%0d", k), err_w[k], mon_e.err);
`endif
          end
        end
      end
    end
  end

  // Present one request on instance k, wait for it to be accepted, and push
  // the expected outcome. With hold set, i_valid stays high afterwards.
  task automatic applyStimulus(input int k, input bit rd, input logic [15:0] a,
                               input logic [7:0] wd, input logic [7:0] so,
                               input bit hold);
    exp_t e;
    bit   bad;
    int   n;
    int   d;
    d = (k == 0) ? 2 : 1;
    @(posedge clk);
    #1;
    valid_w[k] = 1'b1;
    rdnwr_w[k] = rd;
    addr_w[k]  = a;
    wdata_w[k] = wd;
    #1;
    n = 0;
    while (!acc_w[k] && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput($sformatf("accept_seen%0d", k), acc_w[k], 1);
    bad = 1'b0;
`ifdef X_23K640_ADDR_CHK_EN
    bad = (a[15:13] != 3'b000);
`endif
    so_byte[k] = so;
    if (rd && !bad) exp_rdata[k] = so;
    e.inst     = k;
    e.err      = bad;
    e.frame    = bad ? 32'h0 : {(rd ? 8'h03 : 8'h02), a, (rd ? 8'h00 : wd)};
    e.rises    = bad ? 0 : 32;
    e.lat      = bad ? 1 : 1 + 65 * d;
    e.cs_first = bad ? -1 : 1;
    e.cs_last  = bad ? -1 : 65 * d;
    e.rdata    = exp_rdata[k];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) valid_w[k] = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("txn_complete", sb.size(), 0);
  endtask

  initial begin
    int first_acc;
    int n;
    int rc;
    valid_w = '0;
    rdnwr_w = '0;
    addr_w  = '0;
    wdata_w = '0;
    for (int k = 0; k < 2; k++) begin
      exp_rdata[k] = 8'h00;
      so_byte[k]   = 8'h00;
      acc_cyc[k]   = 0;
      ready_cnt[k] = 0;
      spurious[k]  = 0;
      bad_edge[k]  = 1'b0;
      mosi_unst[k] = 1'b0;
    end

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cs_n", csn_w[0], 1);
    checkOutput("rst_sck", sck_w[0], 0);
    checkOutput("rst_mosi", mosi_w[0], 0);
    checkOutput("rst_ready", ready_w[0], 0);
    checkOutput("rst_rdata", rdata_w[0], 8'h00);
`ifdef X_23K640_ADDR_CHK_EN
    checkOutput("rst_err", err_w[0], 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write then read at 16'h0123, D=2.
    applyStimulus(0, 1'b0, 16'h0123, 8'hA5, 8'h00, 1'b0);
    waitDone(400);
    applyStimulus(0, 1'b1, 16'h0123, 8'h00, 8'h5A, 1'b0);
    waitDone(400);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("rdata_held", rdata_w[0], 8'h5A);

    // Back-to-back with i_valid held high across both requests.
    applyStimulus(0, 1'b0, 16'h0456, 8'h3C, 8'h00, 1'b1);
    first_acc = acc_cyc[0];
    applyStimulus(0, 1'b1, 16'h0789, 8'h00, 8'hC3, 1'b0);
    checkOutput("b2b_spacing", acc_cyc[0] - first_acc, 1 + 66 * 2);
    waitDone(400);

    // Reset pulsed during bit 10 of a write.
    applyStimulus(0, 1'b0, 16'h0ABC, 8'h77, 8'h00, 1'b0);
    n = 0;
    while (rises[0] < 11 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reached_bit10", rises[0], 11);
    rst = 1'b1;
    sb.delete();
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_cs_n", csn_w[0], 1);
    checkOutput("abort_sck", sck_w[0], 0);
    checkOutput("abort_mosi", mosi_w[0], 0);
    checkOutput("abort_rdata", rdata_w[0], 8'h00);
    rc = ready_cnt[0];
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    checkOutput("no_ready_after_abort", ready_cnt[0], rc);

    // D=1 read at the top of the 8 KB array.
    applyStimulus(1, 1'b1, 16'h1FFF, 8'h00, 8'h96, 1'b0);
    waitDone(400);

`ifdef X_23K640_ADDR_CHK_EN
    // Out-of-range address: immediate ready+err, no frame, rdata untouched.
    applyStimulus(0, 1'b1, 16'h2000, 8'h00, 8'hFF, 1'b0);
    waitDone(50);
    @(negedge clk);
    checkOutput("oor_rdata_kept", rdata_w[0], 8'h00);
`endif

    checkOutput("spurious_ready0", spurious[0], 0);
    checkOutput("spurious_ready1", spurious[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
